iob_vexriscv_axi_rd_arb: RTL

Two-master, one-slave AXI4 read-channel arbiter placed between the VexRiscv CPU wrapper's instruction-bus and data-bus read channels and the single AXI read port of the system memory interconnect. It grants the shared AR/R channel to one bus for exactly one burst at a time: from AR accept until the last R beat. A beat counter checks each burst against its `arlen`. Write channels do not pass through this block; they stay dBus-only and connect directly.

---
 rtl/iob_vexriscv_axi_arb_pkg.sv | 35 +++
 rtl/iob_arb2_rr.sv | 33 +++
 rtl/iob_vexriscv_axi_rd_arb.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/iob_vexriscv_axi_arb_pkg.sv
// Shared definitions for the VexRiscv AXI read-channel arbiter: FSM encoding,
// AR/R field offsets (LSB-relative) and master indices.
package iob_vexriscv_axi_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2
    } arb_state_t;

    // AR packing, LSB first: arprot, arqos, arcache, arlock, arburst, arsize, arlen, araddr, arid
    localparam int AR_PROT_OFF  = 0;
    localparam int AR_QOS_OFF   = 3;
    localparam int AR_CACHE_OFF = 7;
    localparam int AR_LOCK_OFF  = 11;
    localparam int AR_BURST_OFF = 13;
    localparam int AR_SIZE_OFF  = 15;
    localparam int AR_LEN_OFF   = 18;
    localparam int AR_FIXED_W   = 18;

    // R packing, LSB first: rlast, rresp, rdata, rid
    localparam int R_LAST_OFF = 0;
    localparam int R_RESP_OFF = 1;
    localparam int R_DATA_OFF = 3;
    localparam int R_FIXED_W  = 3;

    localparam logic IBUS = 1'b0;
    localparam logic DBUS = 1'b1;

    // The master that did not receive the most recent grant.
    function automatic logic other_master(input logic last_grant);
        return (last_grant == IBUS) ? DBUS : IBUS;
    endfunction

endpackage

// File: rtl/iob_arb2_rr.sv
// Combinational two-requester grant. IOB_VEXRISCV_AXI_RD_ARB_RR_EN selects
// round-robin on contention; otherwise dBus has fixed priority over iBus.
module iob_arb2_rr
    import iob_vexriscv_axi_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic       gnt_valid,
    output logic       gnt_idx
);

`ifndef IOB_VEXRISCV_AXI_RD_ARB_RR_EN
    logic unused_last_grant_s;
    assign unused_last_grant_s = last_grant;
`endif

    // Pick one requester; contention resolution depends on the build option.
    always_comb begin
        gnt_valid = |req;
        gnt_idx   = IBUS;
        case (req)
            2'b01:   gnt_idx = IBUS;
            2'b10:   gnt_idx = DBUS;
`ifdef IOB_VEXRISCV_AXI_RD_ARB_RR_EN
            2'b11:   gnt_idx = other_master(last_grant);
`else
            2'b11:   gnt_idx = DBUS;
`endif
            default: gnt_idx = IBUS;
        endcase
    end

endmodule

// File: rtl/iob_vexriscv_axi_rd_arb.sv
// Two-master, one-slave AXI4 read arbiter (iBus/dBus -> memory), one burst at
// a time. Build option IOB_VEXRISCV_AXI_RD_ARB_RR_EN enables round-robin.
module iob_vexriscv_axi_rd_arb
    import iob_vexriscv_axi_arb_pkg::*;
#(
    parameter int ID_W   = 1,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int LEN_W  = 8,
    parameter int AR_W   = ID_W + ADDR_W + LEN_W + 18,
    parameter int R_W    = ID_W + DATA_W + 3
) (
    input  logic            clk_i,
    input  logic            cke_i,
    input  logic            arst_n_i,

    input  logic            ibus_arvalid_i,
    output logic            ibus_arready_o,
    input  logic [AR_W-1:0] ibus_ar_i,
    output logic            ibus_rvalid_o,
    input  logic            ibus_rready_i,
    output logic [R_W-1:0]  ibus_r_o,

    input  logic            dbus_arvalid_i,
    output logic            dbus_arready_o,
    input  logic [AR_W-1:0] dbus_ar_i,
    output logic            dbus_rvalid_o,
    input  logic            dbus_rready_i,
    output logic [R_W-1:0]  dbus_r_o,

    output logic            axi_arvalid_o,
    input  logic            axi_arready_i,
    output logic [AR_W-1:0] axi_ar_o,
    input  logic            axi_rvalid_i,
    output logic            axi_rready_o,
    input  logic [R_W-1:0]  axi_r_i,

    output logic            err_o
);

    arb_state_t       state_r, state_nxt_s;
    logic             sel_r, sel_nxt_s;
    logic [LEN_W-1:0] beats_r, beats_nxt_s;
    logic             err_r, err_nxt_s;
    logic             last_grant_s;

    logic             gnt_valid_s, gnt_idx_s;
    logic             sel_arvalid_s, sel_rready_s;
    logic [AR_W-1:0]  sel_ar_s;
    logic [LEN_W-1:0] sel_arlen_s;
    logic             r_hs_s, rlast_s;

`ifdef IOB_VEXRISCV_AXI_RD_ARB_RR_EN
    logic             last_grant_r, last_grant_nxt_s;
    assign last_grant_s = last_grant_r;
`else
    assign last_grant_s = DBUS;
`endif

    assign sel_arvalid_s = (sel_r == DBUS) ? dbus_arvalid_i : ibus_arvalid_i;
    assign sel_ar_s      = (sel_r == DBUS) ? dbus_ar_i      : ibus_ar_i;
    assign sel_rready_s  = (sel_r == DBUS) ? dbus_rready_i  : ibus_rready_i;
    assign sel_arlen_s   = sel_ar_s[AR_LEN_OFF +: LEN_W];
    assign rlast_s       = axi_r_i[R_LAST_OFF];
    assign r_hs_s        = axi_rvalid_i & sel_rready_s;

    iob_arb2_rr u_arb (
        .req        ({dbus_arvalid_i, ibus_arvalid_i}),
        .last_grant (last_grant_s),
        .gnt_valid  (gnt_valid_s),
        .gnt_idx    (gnt_idx_s)
    );

    // Next-state logic: grant in IDLE, AR handshake in ADDR, beat counting in DATA.
    always_comb begin
        state_nxt_s = state_r;
        sel_nxt_s   = sel_r;
        beats_nxt_s = beats_r;
        err_nxt_s   = err_r;
`ifdef IOB_VEXRISCV_AXI_RD_ARB_RR_EN
        last_grant_nxt_s = last_grant_r;
`endif
        case (state_r)
            ST_IDLE: begin
                if (gnt_valid_s) begin
                    sel_nxt_s   = gnt_idx_s;
                    state_nxt_s = ST_ADDR;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_ADDR: begin
                if (sel_arvalid_s && axi_arready_i) begin
                    beats_nxt_s = sel_arlen_s;
                    state_nxt_s = ST_DATA;
`ifdef IOB_VEXRISCV_AXI_RD_ARB_RR_EN
                    last_grant_nxt_s = sel_r;
`endif
                end else if (!sel_arvalid_s) begin
                    // master withdrew its request before the slave took it
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_ADDR;
                end
            end
            ST_DATA: begin
                if (r_hs_s) begin
                    // counter saturates so an overrun burst keeps reporting a mismatch
                    if (beats_r != {LEN_W{1'b0}}) begin
                        beats_nxt_s = beats_r - {{(LEN_W-1){1'b0}}, 1'b1};
                    end else begin
                        beats_nxt_s = {LEN_W{1'b0}};
                    end
                    if (rlast_s) begin
                        state_nxt_s = ST_IDLE;
                        if (beats_r != {LEN_W{1'b0}}) begin
                            err_nxt_s = 1'b1;
                        end else begin
                            err_nxt_s = err_r;
                        end
                    end else if (beats_r == {LEN_W{1'b0}}) begin
                        err_nxt_s = 1'b1;
                    end else begin
                        err_nxt_s = err_r;
                    end
                end else begin
                    state_nxt_s = ST_DATA;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State, grant, beat counter and sticky error; frozen while cke_i is low.
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            state_r <= ST_IDLE;
            sel_r   <= IBUS;
            beats_r <= {LEN_W{1'b0}};
            err_r   <= 1'b0;
        end else if (cke_i) begin
            state_r <= state_nxt_s;
            sel_r   <= sel_nxt_s;
            beats_r <= beats_nxt_s;
            err_r   <= err_nxt_s;
        end
    end

`ifdef IOB_VEXRISCV_AXI_RD_ARB_RR_EN
    // Last-grant history: reset to dBus so iBus wins the first contention.
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            last_grant_r <= DBUS;
        end else if (cke_i) begin
            last_grant_r <= last_grant_nxt_s;
        end
    end
`endif

    // Channel steering: only the granted master sees the slave, and only in its phase.
    always_comb begin
        axi_arvalid_o  = 1'b0;
        axi_ar_o       = {AR_W{1'b0}};
        axi_rready_o   = 1'b0;
        ibus_arready_o = 1'b0;
        dbus_arready_o = 1'b0;
        ibus_rvalid_o  = 1'b0;
        dbus_rvalid_o  = 1'b0;
        ibus_r_o       = {R_W{1'b0}};
        dbus_r_o       = {R_W{1'b0}};
        if (state_r == ST_ADDR) begin
            axi_arvalid_o = sel_arvalid_s;
            axi_ar_o      = sel_ar_s;
            if (sel_r == DBUS) begin
                dbus_arready_o = axi_arready_i;
            end else begin
                ibus_arready_o = axi_arready_i;
            end
        end else if (state_r == ST_DATA) begin
            axi_rready_o = sel_rready_s;
            if (sel_r == DBUS) begin
                dbus_rvalid_o = axi_rvalid_i;
                dbus_r_o      = axi_r_i;
            end else begin
                ibus_rvalid_o = axi_rvalid_i;
                ibus_r_o      = axi_r_i;
            end
        end else begin
            axi_rready_o = 1'b0;
        end
    end

    assign err_o = err_r;

endmodule
